tetris_ctrl: RTL

Game sequencer for the Tetris datapath. It drives the datapath's 4-bit `state` bus through the GEN/MOVE/LAND/CLEAR/NEWBOARD/GAMEOVER cycle and arbitrates player buttons against an internal gravity timer onto the single 2-bit `move` channel. It sits between the button front-end and `dp`, consuming `touched` and the datapath game-over flag.

---
 rtl/tetris_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tetris_ctrl.sv
// Tetris game sequencer: drives the datapath state bus and arbitrates buttons vs. gravity onto one move channel.
// All outputs registered (one cycle after inputs); at most one move per ISSUE/WAIT pair. Soft drop: TETRIS_SOFT_DROP_EN.
module tetris_ctrl #(
  parameter int DROP_TICKS = 16
) (
  input  logic       clka,
  input  logic       restart,
  input  logic       start,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_rotate,
  input  logic       btn_down,
  input  logic       touched,
  input  logic       game_over,
  output logic [3:0] state,
  output logic [1:0] move,
  output logic       move_strobe,
  output logic [7:0] piece_count
);

  localparam logic [3:0] ST_GEN      = 4'd0;
  localparam logic [3:0] ST_MOVE     = 4'd1;
  localparam logic [3:0] ST_LAND     = 4'd2;
  localparam logic [3:0] ST_CLEAR    = 4'd3;
  localparam logic [3:0] ST_NEWBOARD = 4'd4;
  localparam logic [3:0] ST_GAMEOVER = 4'd5;

  localparam logic SUB_ISSUE = 1'b0;
  localparam logic SUB_WAIT  = 1'b1;

  localparam logic [7:0] TICK_LAST = 8'(DROP_TICKS - 1);

`ifdef TETRIS_SOFT_DROP_EN
  localparam logic SOFT_DROP = 1'b1;
`else
  localparam logic SOFT_DROP = 1'b0;
`endif

  logic [3:0] r_state, w_state_nxt;
  logic       r_sub, w_sub_nxt;
  // Pending flags indexed by move code: [0]=left [1]=right [2]=rotate [3]=drop
  logic [3:0] r_pend, w_pend_nxt;
  logic [3:0] r_btn_q;
  logic [3:0] w_edge;
  logic       w_down_edge;
  logic [7:0] r_cnt, w_cnt_nxt;
  logic       w_tick;
  logic [1:0] r_move, w_move_nxt;
  logic       r_strobe, w_strobe_nxt;
  logic [7:0] r_pc, w_pc_nxt;

  assign w_edge      = {btn_down, btn_rotate, btn_right, btn_left} & ~r_btn_q;
  assign w_down_edge = SOFT_DROP & w_edge[3];
  assign w_tick      = (r_state == ST_MOVE) && (r_cnt == TICK_LAST);

  always_ff @(posedge clka) begin
    if (restart) begin
      r_state <= ST_NEWBOARD;
      r_sub   <= SUB_ISSUE;
    end else begin
      r_state <= w_state_nxt;
      r_sub   <= w_sub_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sub_nxt   = r_sub;
    case (r_state)
      ST_NEWBOARD: if (start) w_state_nxt = ST_GEN;
      ST_GEN: begin
        w_state_nxt = game_over ? ST_GAMEOVER : ST_MOVE;
        w_sub_nxt   = SUB_ISSUE;
      end
      ST_MOVE: begin
        if (r_sub == SUB_WAIT) begin
          w_sub_nxt = SUB_ISSUE;
          if (touched) w_state_nxt = ST_LAND;
        end else if (r_strobe) begin
          w_sub_nxt = SUB_WAIT;
        end
      end
      ST_LAND:     w_state_nxt = ST_CLEAR;
      ST_CLEAR:    w_state_nxt = ST_GEN;
      ST_GAMEOVER: if (start) w_state_nxt = ST_NEWBOARD;
      default:     w_state_nxt = ST_NEWBOARD;
    endcase
  end

  // Outputs are registered from next-cycle values so a flag set at an edge can strobe in the very next cycle.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == ST_GEN)       w_cnt_nxt = 8'd0;
    else if (r_state == ST_MOVE) w_cnt_nxt = w_tick ? 8'd0 : r_cnt + 8'd1;
    if (w_down_edge)             w_cnt_nxt = 8'd0;

    w_pend_nxt = r_pend;
    if (r_state == ST_GEN) w_pend_nxt = 4'd0;
    else if (r_strobe)     w_pend_nxt[r_move] = 1'b0;
    w_pend_nxt = w_pend_nxt | {w_tick | w_down_edge, w_edge[2:0]};

    w_pc_nxt = r_pc;
    if ((r_state == ST_LAND) && (r_pc != 8'hFF))   w_pc_nxt = r_pc + 8'd1;
    else if ((r_state == ST_GAMEOVER) && start)    w_pc_nxt = 8'd0;

    w_strobe_nxt = (w_state_nxt == ST_MOVE) && (w_sub_nxt == SUB_ISSUE) && (|w_pend_nxt);
    w_move_nxt   = r_move;
    if (w_strobe_nxt) begin
      if (w_pend_nxt[3])      w_move_nxt = 2'd3;
      else if (w_pend_nxt[2]) w_move_nxt = 2'd2;
      else if (w_pend_nxt[0]) w_move_nxt = 2'd0;
      else                    w_move_nxt = 2'd1;
    end
  end

  always_ff @(posedge clka) begin
    if (restart) begin
      r_pend   <= 4'd0;
      r_btn_q  <= 4'd0;
      r_cnt    <= 8'd0;
      r_move   <= 2'd3;
      r_strobe <= 1'b0;
      r_pc     <= 8'd0;
    end else begin
      r_pend   <= w_pend_nxt;
      r_btn_q  <= {btn_down, btn_rotate, btn_right, btn_left};
      r_cnt    <= w_cnt_nxt;
      r_move   <= w_move_nxt;
      r_strobe <= w_strobe_nxt;
      r_pc     <= w_pc_nxt;
    end
  end

  assign state       = r_state;
  assign move        = r_move;
  assign move_strobe = r_strobe;
  assign piece_count = r_pc;

endmodule
